ex_div: RTL and testbench

- Multi-cycle radix-2 restoring divider inside the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the operand pair and DIV/DIVU opcode latched by ID/EX and returns {remainder, quotient} for the HI/LO write path.
- EX holds start_i and raises its stall request until ready_o.
- Flush and annul abort an in-flight division.

---
 rtl/ex_div.sv | 178 +++++++++++++++++
 tb/tb_ex_div.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
// Module      : ex_div
// Description : EX-stage multi-cycle radix-2 restoring divider (DIV/DIVU),
//               returns {remainder, quotient}. Optional DIV_EARLY_EXIT_EN
//               short-circuits |dividend| < |divisor| in two edges.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 annul_i,
    input  logic                 start_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;
`ifdef DIV_EARLY_EXIT_EN
    logic                 early_q, early_d;
`endif

    logic [WIDTH-1:0]     w_abs1, w_abs2;
    logic [WIDTH:0]       w_shift, w_diff;
    logic [WIDTH-1:0]     w_rem_nxt, w_quo_nxt, w_rem_fix, w_quo_fix;

    assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // One restoring step: the dividend MSB shifts into the partial remainder
    assign w_shift   = {rem_q, quo_q[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, dvsr_q};
    assign w_rem_nxt = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_nxt = {quo_q[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_rem_fix = neg_rem_q ? -w_rem_nxt : w_rem_nxt;
    assign w_quo_fix = neg_quo_q ? -w_quo_nxt : w_quo_nxt;

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q == ON) || (state_q == BYZERO);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;
`ifdef DIV_EARLY_EXIT_EN
        early_d   = early_q;
`endif
        if (flush || annul_i) begin
            state_d  = FREE;
            ready_d  = 1'b0;
            result_d = '0;
        end else begin
            case (state_q)
                FREE: begin
                    if (start_i) begin
                        cnt_d     = '0;
                        rem_d     = '0;
                        quo_d     = w_abs1;
                        dvsr_d    = w_abs2;
                        neg_quo_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_d = signed_div_i && opdata1_i[WIDTH-1];
`ifdef DIV_EARLY_EXIT_EN
                        early_d   = 1'b0;
`endif
                        if (opdata2_i == '0) begin
                            state_d = BYZERO;
                        end
`ifdef DIV_EARLY_EXIT_EN
                        // Quotient is zero; the remainder is the untouched signed dividend
                        else if (w_abs1 < w_abs2) begin
                            state_d = BYZERO;
                            early_d = 1'b1;
                            quo_d   = opdata1_i;
                        end
`endif
                        else begin
                            state_d = ON;
                        end
                    end
                end
                BYZERO: begin
                    state_d = END;
                    ready_d = 1'b1;
`ifdef DIV_EARLY_EXIT_EN
                    result_d = early_q ? {quo_q, {WIDTH{1'b0}}} : '0;
`else
                    result_d = '0;
`endif
                end
                ON: begin
                    rem_d = w_rem_nxt;
                    quo_d = w_quo_nxt;
                    cnt_d = cnt_q + c_one;
                    if (cnt_q == c_last) begin
                        state_d  = END;
                        ready_d  = 1'b1;
                        result_d = {w_rem_fix, w_quo_fix};
                    end
                end
                END: begin
                    if (!start_i) begin
                        state_d  = FREE;
                        ready_d  = 1'b0;
                        result_d = '0;
                    end
                end
                default: begin
                    state_d = FREE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
`ifdef DIV_EARLY_EXIT_EN
            early_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
`ifdef DIV_EARLY_EXIT_EN
            early_q   <= early_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_div
// Description : Directed self-checking bench for ex_div (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        annul_i;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_total = 0;
    int n_bad   = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam int c_small_edges = 2;
    localparam int c_small_busy  = 1;
`else
    localparam int c_small_edges = 33;
    localparam int c_small_busy  = 32;
`endif

    ex_div #(.WIDTH(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .annul_i      (annul_i),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Issue one division, hold start_i until ready_o, then release it
    task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res,
                           input int exp_edges, input int exp_busy);
        int edges;
        int busy_n;
        edges  = 0;
        busy_n = 0;
        @(negedge clk);
        start_i      = 1'b1;
        signed_div_i = sd;
        opdata1_i    = a;
        opdata2_i    = b;
        while (edges < 40 && !ready_o) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy_o) busy_n++;
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~signed_div_i;
        end
        chk({tag, "_edges"}, 64'(edges), 64'(exp_edges));
        chk({tag, "_busy"}, 64'(busy_n), 64'(exp_busy));
        chk({tag, "_result"}, result_o, exp_res);
        @(posedge clk);
        #1;
        chk({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
        chk({tag, "_hold_result"}, result_o, exp_res);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
        chk({tag, "_drop_result"}, result_o, 64'd0);
    endtask

    task automatic quiet_check(input string tag);
        int hits;
        hits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o || busy_o) hits++;
        end
        chk({tag, "_quiet"}, 64'(hits), 64'd0);
    endtask

    // Abort a DIVU 100/7 while at ON iteration 10
    task automatic abort_mid(input string tag, input logic use_annul);
        @(negedge clk);
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        repeat (11) @(posedge clk);
        @(negedge clk);
        if (use_annul) annul_i = 1'b1;
        else           flush   = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_ready"}, 64'(ready_o), 64'd0);
        @(negedge clk);
        flush   = 1'b0;
        annul_i = 1'b0;
        start_i = 1'b0;
        quiet_check(tag);
        run_div({tag, "_after"}, 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 32);
    endtask

    initial begin
        rst          = 1'b0;
        flush        = 1'b0;
        annul_i      = 1'b0;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result_o, 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 32);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 32);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33, 32);
        run_div("div_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'h2}, 33, 32);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 32);
        run_div("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33, 32);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 64'd0, 2, 1);
        run_div("divu_3_10", 1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, c_small_edges, c_small_busy);
        run_div("div_m3_7", 1'b1, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFD, 32'd0}, c_small_edges, c_small_busy);

        abort_mid("flush_mid", 1'b0);
        abort_mid("annul_mid", 1'b1);

        // start_i and flush on the same edge in FREE: not accepted
        @(negedge clk);
        start_i   = 1'b1;
        flush     = 1'b1;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        @(posedge clk);
        #1;
        chk("flush_start_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        flush   = 1'b0;
        quiet_check("flush_start");

        // Asynchronous reset mid-ON
        @(negedge clk);
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        repeat (6) @(posedge clk);
        #3;
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy_o), 64'd0);
        chk("async_rst_ready", 64'(ready_o), 64'd0);
        chk("async_rst_result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b1;
        quiet_check("post_rst");
        run_div("post_rst_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 32);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
